run_detector: RTL and testbench

RUN_DETECTOR -- requirements
Module: run_detector

---
 rtl/run_det_pkg.sv | 32 +++
 rtl/sat_counter.sv | 23 ++
 rtl/run_detector.sv | 82 ++++++++
 tb/tb_run_detector.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/run_det_pkg.sv
// Shared types for the run detector: FSM state encoding, detection modes,
// and the rule deciding whether a run's polarity is being watched.
package run_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN0 = 2'b01,
    RUN1 = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    MODE_ONES   = 2'b00,
    MODE_ZEROS  = 2'b01,
    MODE_EITHER = 2'b10,
    MODE_OFF    = 2'b11
  } mode_t;

  localparam int RUN_LEN_MIN = 2;
  localparam int RUN_LEN_MAX = 15;

  function automatic logic polarity_enabled(input mode_t m, input state_t s);
    logic en;
    case (m)
      MODE_ONES:   en = (s == RUN1);
      MODE_ZEROS:  en = (s == RUN0);
      MODE_EITHER: en = (s != IDLE);
      default:     en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Inc,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      q_reg <= '0;
    end else if (Inc && (q_reg != {WIDTH{1'b1}})) begin
      q_reg <= q_reg + WIDTH'(1);
    end
  end

  assign Q = q_reg;

endmodule

// File: rtl/run_detector.sv
// Serial run detector: tracks the current run of identical bits and flags
// runs of RUN_LEN or more whose polarity the selected mode is watching.
module run_detector
  import run_det_pkg::*;
#(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             En,
  input  logic             W,
  input  logic [1:0]       Mode,
  output logic             Z,
  output logic [3:0]       RunCount,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] MatchCount
);

  generate
    if (RUN_LEN < RUN_LEN_MIN || RUN_LEN > RUN_LEN_MAX) begin : g_bad_run_len
      $error("run_detector: RUN_LEN must be within 2..15");
    end
    if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cnt_w
      $error("run_detector: CNT_W must be within 1..16");
    end
  endgenerate

  localparam logic [3:0] RUN_LEN_C = 4'(RUN_LEN);

  state_t     state_reg, state_next, sample_state;
  logic [3:0] run_cnt_reg, run_cnt_next;
  logic       z_reg, z_next;
  logic       match_inc;

  always_comb begin
    state_next   = state_reg;
    run_cnt_next = run_cnt_reg;
    z_next       = z_reg;
    sample_state = W ? RUN1 : RUN0;
    if (En) begin
      // IDLE never equals a RUN state, so the first sample lands in the restart branch.
      if (state_reg == sample_state) begin
        run_cnt_next = (run_cnt_reg >= RUN_LEN_C) ? RUN_LEN_C : run_cnt_reg + 4'd1;
      end else begin
        run_cnt_next = 4'd1;
      end
      state_next = sample_state;
      z_next     = (run_cnt_next == RUN_LEN_C) &&
                   polarity_enabled(mode_t'(Mode), sample_state);
    end
  end

  // A match is counted only on the rising edge of Z, so overlapping samples do not recount.
  assign match_inc = En && z_next && !z_reg;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg   <= IDLE;
      run_cnt_reg <= 4'd0;
      z_reg       <= 1'b0;
    end else begin
      state_reg   <= state_next;
      run_cnt_reg <= run_cnt_next;
      z_reg       <= z_next;
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_match_cnt (
    .Clock(Clock),
    .Reset(Reset),
    .Inc  (match_inc),
    .Q    (MatchCount)
  );

  assign Z        = z_reg;
  assign RunCount = run_cnt_reg;
  assign State    = state_reg;

endmodule

// File: tb/tb_run_detector.sv
// Directed bench for run_detector: a history-based model checked every cycle
// against two instances (8-bit and 2-bit match counters), plus literal checks.
module tb_run_detector;

  localparam int RL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       w   = 1'b0;
  logic [1:0] mode = 2'b00;

  logic       z8, z2;
  logic [3:0] rc8, rc2;
  logic [1:0] st8, st2;
  logic [7:0] mc8;
  logic [1:0] mc2;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  run_detector #(.RUN_LEN(RL), .CNT_W(8)) dut8 (
    .Clock(clk), .Reset(rst), .En(en), .W(w), .Mode(mode),
    .Z(z8), .RunCount(rc8), .State(st8), .MatchCount(mc8)
  );

  run_detector #(.RUN_LEN(RL), .CNT_W(2)) dut2 (
    .Clock(clk), .Reset(rst), .En(en), .W(w), .Mode(mode),
    .Z(z2), .RunCount(rc2), .State(st2), .MatchCount(mc2)
  );

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endfunction

  // Model: remember sampled bits; the run is the tail of identical bits.
  bit hist[$];
  bit m_z = 1'b0;
  int m_matches = 0;

  function automatic int model_run();
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != hist[hist.size() - 1]) break;
      n++;
    end
    return (n > RL) ? RL : n;
  endfunction

  function automatic bit pol_ok(input logic [1:0] m, input bit b);
    case (m)
      2'b00:   return b;
      2'b01:   return !b;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int model_state();
    if (hist.size() == 0) return 0;
    return hist[hist.size() - 1] ? 2 : 1;
  endfunction

  always @(posedge clk) begin : model_upd
    bit zn;
    if (rst) begin
      hist.delete();
      m_z = 1'b0;
      m_matches = 0;
    end else if (en) begin
      hist.push_back(w);
      if (hist.size() > 32) void'(hist.pop_front());
      zn = (model_run() == RL) && pol_ok(mode, w);
      if (zn && !m_z) m_matches++;
      m_z = zn;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("state8", st8, model_state());
      check("runcnt8", rc8, model_run());
      check("z8", z8, m_z);
      check("match8", mc8, (m_matches > 255) ? 255 : m_matches);
      check("state2", st2, model_state());
      check("runcnt2", rc2, model_run());
      check("z2", z2, m_z);
      check("match2", mc2, (m_matches > 3) ? 3 : m_matches);
    end
  end

  task automatic step(input bit e, input bit b);
    @(negedge clk);
    rst = 1'b0;
    en  = e;
    w   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    w   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t1_rc[5] = '{1, 2, 3, 4, 4};
    int t1_z[5]  = '{0, 0, 0, 1, 1};
    int t2_z[4]  = '{0, 0, 0, 1};
    int t6_mc[5] = '{1, 2, 3, 3, 3};

    // Runs of ones, overlapping tail.
    mode = 2'b00;
    do_reset();
    checking = 1'b1;
    check("rst_state", st8, 0);
    check("rst_runcnt", rc8, 0);
    check("rst_z", z8, 0);
    check("rst_match", mc8, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1);
      check("t1_runcnt", rc8, t1_rc[i]);
      check("t1_z", z8, t1_z[i]);
    end
    check("t1_match", mc8, 1);

    // Zeros-only mode ignores the run of ones.
    mode = 2'b01;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1);
      check("t2_z_ones", z8, 0);
    end
    check("t2_state_run1", st8, 2);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      check("t2_z_zeros", z8, t2_z[i]);
    end
    check("t2_state_run0", st8, 1);
    check("t2_match", mc8, 1);

    // Either polarity.
    mode = 2'b10;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    check("t3_z_ones", z8, 1);
    step(1'b1, 1'b0);
    check("t3_z_break", z8, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    check("t3_z_zeros", z8, 1);
    check("t3_match", mc8, 2);

    // Enable gaps hold everything.
    mode = 2'b00;
    do_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0);
      check("t4_hold_runcnt", rc8, 2);
    end
    step(1'b1, 1'b1);
    check("t4_z_early", z8, 0);
    step(1'b1, 1'b1);
    check("t4_z", z8, 1);
    check("t4_runcnt", rc8, 4);

    // Mid-run reset discards the partial run and the match count.
    mode = 2'b10;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    check("t5_runcnt_pre", rc8, 3);
    check("t5_match_pre", mc8, 1);
    do_reset();
    check("t5_state", st8, 0);
    check("t5_runcnt", rc8, 0);
    check("t5_z", z8, 0);
    check("t5_match", mc8, 0);
    step(1'b1, 1'b1);
    check("t5_first_runcnt", rc8, 1);
    check("t5_first_state", st8, 2);

    // Saturation of the 2-bit counter over five runs.
    mode = 2'b10;
    do_reset();
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) step(1'b1, (r % 2) == 0);
      check("t6_match2", mc2, t6_mc[r]);
      check("t6_match8", mc8, r + 1);
    end

    // Detection off, then enabling a run already at full length.
    mode = 2'b11;
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    check("t7_off_z", z8, 0);
    check("t7_off_match", mc8, 0);
    check("t7_off_runcnt", rc8, 4);
    check("t7_off_state", st8, 2);
    mode = 2'b00;
    step(1'b1, 1'b1);
    check("t7_on_z", z8, 1);
    check("t7_on_match", mc8, 1);
    step(1'b1, 1'b1);
    check("t7_cont_match", mc8, 1);
    mode = 2'b11;
    step(1'b0, 1'b0);
    check("t7_gap_z", z8, 1);
    step(1'b1, 1'b0);
    check("t7_break_z", z8, 0);
    check("t7_break_runcnt", rc8, 1);

    step(1'b0, 1'b0);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
